// File: rtl/paddle_rc_emu.sv
// Paddle pot/RC timer emulation for one player: button (or optional analog) position plus a per-frame line countdown.
// Optional feature macro: PADDLE_ANALOG_EN (analog stick drives position when use_analog=1).
module paddle_rc_emu #(
  parameter int POS_W        = 9,
  parameter int POS_MAX      = 255,
  parameter int POS_INIT     = 128,
  parameter int STEP_SLOW    = 5,
  parameter int STEP_FAST    = 8,
  parameter int ACCEL_FRAMES = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              hs,
  input  logic              vs,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              fast,
  input  logic              use_analog,
  input  logic signed [7:0] analog_y,
  output logic              pin_out,
  output logic [POS_W-1:0]  pos
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

  localparam int               HOLD_W    = $clog2(ACCEL_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(ACCEL_FRAMES);
  localparam logic [POS_W:0]    POS_MAX_X = (POS_W + 1)'(POS_MAX);
  localparam logic [POS_W:0]    STEP_S    = (POS_W + 1)'(STEP_SLOW);
  localparam logic [POS_W:0]    STEP_F    = (POS_W + 1)'(STEP_FAST);

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold, hold_nxt;
  logic [POS_W-1:0]    cap, pos_nxt;
  logic [POS_W:0]      base, step;
  logic                vs_q, hs_q, vs_rise, hs_rise;
  logic                up_only, down_only;

  function automatic logic [POS_W-1:0] sat_sub(input logic [POS_W-1:0] p, input logic [POS_W:0] s);
    logic [POS_W:0] diff;
    diff = {1'b0, p} - s;
    if ({1'b0, p} < s) return '0;
    return diff[POS_W-1:0];
  endfunction

  function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0] p, input logic [POS_W:0] s);
    logic [POS_W:0] sum;
    sum = {1'b0, p} + s;
    if (sum > POS_MAX_X) return POS_MAX_X[POS_W-1:0];
    return sum[POS_W-1:0];
  endfunction

  assign vs_rise   = vs & ~vs_q;
  assign hs_rise   = hs & ~hs_q;
  assign up_only   = btn_up & ~btn_down;
  assign down_only = btn_down & ~btn_up;
  assign pin_out   = (cap == '0);

`ifdef PADDLE_ANALOG_EN
  logic [7:0]     ana_off;
  logic [POS_W:0] ana_x;
  assign ana_off = analog_y ^ 8'h80;
  assign ana_x   = (POS_W + 1)'(ana_off);
`else
  logic unused_analog;
  assign unused_analog = ^{use_analog, analog_y};
`endif

  // Movement decision; only committed on vs_rise
  always_comb begin
    state_nxt = state;
    hold_nxt  = '0;
    pos_nxt   = pos;
    case (state)
      UP: begin
        if (up_only) begin
          state_nxt = UP;
          hold_nxt  = (hold == HOLD_MAX) ? HOLD_MAX : hold + 1'b1;
        end else if (down_only) begin
          state_nxt = DOWN;
        end else begin
          state_nxt = IDLE;
        end
      end
      DOWN: begin
        if (down_only) begin
          state_nxt = DOWN;
          hold_nxt  = (hold == HOLD_MAX) ? HOLD_MAX : hold + 1'b1;
        end else if (up_only) begin
          state_nxt = UP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        if (up_only)        state_nxt = UP;
        else if (down_only) state_nxt = DOWN;
        else                state_nxt = IDLE;
      end
    endcase

    // Doubling kicks in on the frame the run length reaches ACCEL_FRAMES; a fresh run starts at base
    base = fast ? STEP_F : STEP_S;
    step = (hold_nxt == HOLD_MAX) ? (base << 1) : base;
    if (state_nxt == UP)        pos_nxt = sat_sub(pos, step);
    else if (state_nxt == DOWN) pos_nxt = sat_add(pos, step);

`ifdef PADDLE_ANALOG_EN
    if (use_analog) begin
      state_nxt = IDLE;
      hold_nxt  = '0;
      pos_nxt   = (ana_x > POS_MAX_X) ? POS_MAX_X[POS_W-1:0] : ana_x[POS_W-1:0];
    end
`endif
  end

  // Edge registers, countdown and position state
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vs_q  <= 1'b0;
      hs_q  <= 1'b0;
      cap   <= '0;
      pos   <= POS_W'(POS_INIT);
      state <= IDLE;
      hold  <= '0;
    end else begin
      vs_q <= vs;
      hs_q <= hs;
      if (vs_rise) begin
        cap   <= pos;
        pos   <= pos_nxt;
        state <= state_nxt;
        hold  <= hold_nxt;
      end else if (hs_rise && cap != '0) begin
        cap <= cap - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_paddle_rc_emu.sv
// Directed bench for paddle_rc_emu: frame-by-frame position table plus countdown/reset corner sequences.
module tb_paddle_rc_emu;

  logic              clk_sys = 1'b0;
  logic              reset, hs, vs, btn_up, btn_down, fast, use_analog;
  logic signed [7:0] analog_y;
  logic              pin_out;
  logic [8:0]        pos;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic up;
    logic down;
    logic fst;
    int   exp_pos;
  } vec_t;

  vec_t vq[$];

  paddle_rc_emu dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .hs         (hs),
    .vs         (vs),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .fast       (fast),
    .use_analog (use_analog),
    .analog_y   (analog_y),
    .pin_out    (pin_out),
    .pos        (pos)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic vs_pulse();
    vs = 1'b1; tick();
    vs = 1'b0; tick();
  endtask

  task automatic hs_pulse();
    hs = 1'b1; tick();
    hs = 1'b0; tick();
  endtask

  task automatic hs_n(input int n);
    for (int i = 0; i < n; i++) hs_pulse();
  endtask

  // Pulse hs until pin_out rises; n = number of hs pulses, -1 if it never does
  task automatic count_expire(output int n);
    n = -1;
    for (int i = 1; i <= 600 && n < 0; i++) begin
      hs_pulse();
      if (pin_out === 1'b1) n = i;
    end
  endtask

  task automatic set_btn(input logic u, input logic d, input logic f);
    btn_up = u; btn_down = d; fast = f;
  endtask

  initial begin
    int n, e, h, stp;
    logic saw_low;

    reset = 1'b1; hs = 1'b0; vs = 1'b0; use_analog = 1'b0; analog_y = 8'sd0;
    set_btn(1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("reset_pin", pin_out, 1);
    chk("reset_pos", pos, 128);
    reset = 1'b0;
    tick();
    chk("post_reset_pin", pin_out, 1);

    // Countdown of 128 lines from initial position
    vs_pulse();
    chk("vs_pin_low", pin_out, 0);
    chk("vs_pos", pos, 128);
    count_expire(n);
    chk("expire_128", n, 128);

    vq.push_back('{1'b0, 1'b1, 1'b0, 133});
    vq.push_back('{1'b0, 1'b1, 1'b0, 138});
    vq.push_back('{1'b0, 1'b1, 1'b0, 143});
    vq.push_back('{1'b0, 1'b1, 1'b0, 148});
    vq.push_back('{1'b0, 1'b1, 1'b0, 158});
    vq.push_back('{1'b0, 1'b1, 1'b0, 168});
    vq.push_back('{1'b1, 1'b1, 1'b0, 168});
    vq.push_back('{1'b1, 1'b0, 1'b1, 160});
    vq.push_back('{1'b1, 1'b0, 1'b1, 152});
    vq.push_back('{1'b0, 1'b1, 1'b1, 160});
    vq.push_back('{1'b0, 1'b0, 1'b1, 160});
    vq.push_back('{1'b0, 1'b1, 1'b1, 168});
    vq.push_back('{1'b0, 1'b1, 1'b1, 176});
    vq.push_back('{1'b0, 1'b1, 1'b1, 184});
    vq.push_back('{1'b0, 1'b1, 1'b1, 192});
    vq.push_back('{1'b0, 1'b1, 1'b1, 208});
    vq.push_back('{1'b0, 1'b1, 1'b1, 224});
    vq.push_back('{1'b0, 1'b1, 1'b1, 240});
    vq.push_back('{1'b0, 1'b1, 1'b1, 255});
    vq.push_back('{1'b1, 1'b1, 1'b1, 255});
    for (int i = 0; i < 5; i++) vq.push_back('{1'b0, 1'b1, 1'b0, 255});
    vq.push_back('{1'b1, 1'b0, 1'b0, 250});

    // Buttons change only right before each vs edge
    foreach (vq[i]) begin
      set_btn(vq[i].up, vq[i].down, vq[i].fst);
      vs_pulse();
      chk($sformatf("vec%0d_pos", i), pos, vq[i].exp_pos);
    end

    // Simultaneous vs/hs edge with 10 lines left: reload, no decrement
    set_btn(1'b0, 1'b0, 1'b0);
    vs_pulse();
    chk("idle_pos", pos, 250);
    hs_n(240);
    chk("cap10_pin", pin_out, 0);
    vs = 1'b1; hs = 1'b1; tick();
    vs = 1'b0; hs = 1'b0; tick();
    chk("same_edge_pin", pin_out, 0);
    count_expire(n);
    chk("same_edge_reload", n, 250);

    // Reset mid-countdown with 40 lines left
    vs_pulse();
    hs_n(210);
    chk("cap40_pin", pin_out, 0);
    reset = 1'b1; tick();
    chk("midreset_pin", pin_out, 1);
    chk("midreset_pos", pos, 128);
    reset = 1'b0; tick();

    // Fast up held to the floor; saturates at 0
    set_btn(1'b1, 1'b0, 1'b1);
    e = 128; h = -1;
    for (int i = 0; i < 12; i++) begin
      h   = (h < 4) ? h + 1 : 4;
      stp = (h == 4) ? 16 : 8;
      e   = (e < stp) ? 0 : e - stp;
      vs_pulse();
      chk($sformatf("up_floor%0d", i), pos, e);
    end
    chk("floor_pos", pos, 0);
    vs_pulse();
    chk("zero_frame_pin", pin_out, 1);
    saw_low = 1'b0;
    for (int i = 0; i < 50; i++) begin
      hs_pulse();
      if (pin_out !== 1'b1) saw_low = 1'b1;
    end
    chk("zero_frame_stays_high", saw_low, 0);

    // Analog source (button-driven expectations when the feature is absent)
    reset = 1'b1; tick(); reset = 1'b0; tick();
    use_analog = 1'b1;
    set_btn(1'b0, 1'b1, 1'b0);
    analog_y = -8'sd128; vs_pulse();
`ifdef PADDLE_ANALOG_EN
    chk("analog_min", pos, 0);
`else
    chk("analog_min", pos, 133);
`endif
    analog_y = 8'sd127; vs_pulse();
`ifdef PADDLE_ANALOG_EN
    chk("analog_max", pos, 255);
`else
    chk("analog_max", pos, 138);
`endif
    set_btn(1'b1, 1'b0, 1'b0);
    analog_y = 8'sd0; vs_pulse();
`ifdef PADDLE_ANALOG_EN
    chk("analog_mid", pos, 128);
`else
    chk("analog_mid", pos, 133);
`endif
    use_analog = 1'b0;
    set_btn(1'b0, 1'b1, 1'b0);
    vs_pulse();
`ifdef PADDLE_ANALOG_EN
    chk("analog_resume", pos, 133);
`else
    chk("analog_resume", pos, 138);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
